// File: rtl/eth_rx_frame_ctrl.sv
// Bit-serial Ethernet RX sequencer: SFD hunt, FCS checker control, byte assembly, frame status.
// Optional per-frame good/bad counters are built when ETH_RX_STATS_EN is defined.
module eth_rx_frame_ctrl #(
    parameter int unsigned MIN_LEN      = 64,
    parameter int unsigned MAX_LEN      = 1518,
    parameter int unsigned MAX_PRE_BITS = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_dv,
    input  logic        rx_bit,
    output logic        fcs_rst,
    output logic        fcs_en,
    output logic        fcs_bit,
    input  logic        fcs_ok,
    output logic [7:0]  byte_data,
    output logic        byte_valid,
    output logic        byte_sof,
    output logic        frame_done,
    output logic        frame_good,
    output logic [10:0] frame_len,
    output logic        err_fcs,
    output logic        err_align,
    output logic        err_len,
    output logic [15:0] stat_good,
    output logic [15:0] stat_bad
);

    localparam int unsigned LEN_W = 11;
    localparam int unsigned PRE_W = $clog2(MAX_PRE_BITS + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PRE  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam logic [7:0] SFD = 8'hD5;

    logic [1:0]       state, state_n;
    logic [7:0]       sr, sr_n;
    logic [PRE_W-1:0] pre_cnt, pre_cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [LEN_W-1:0] byte_cnt, byte_cnt_n;
    logic             first, first_n;

    logic [7:0]       byte_data_n;
    logic             byte_valid_n, byte_sof_n, frame_done_n, frame_good_n;
    logic [LEN_W-1:0] frame_len_n;
    logic             err_fcs_n, err_align_n, err_len_n;

    logic [7:0]       sr_shift;
    logic [PRE_W-1:0] pre_cnt_inc;

    // Line bits arrive LSB first, so each new bit enters at the top
    assign sr_shift    = {rx_bit, sr[7:1]};
    assign pre_cnt_inc = pre_cnt + PRE_W'(1);

    // Checker runs only on frame bits and sits in its all-ones reset otherwise
    assign fcs_bit = rx_bit;
    assign fcs_en  = (state == S_DATA) && rx_dv;
    assign fcs_rst = reset || (state != S_DATA);

    // Next-state and registered-output logic
    always_comb begin
        state_n      = state;
        sr_n         = sr;
        pre_cnt_n    = pre_cnt;
        bit_cnt_n    = bit_cnt;
        byte_cnt_n   = byte_cnt;
        first_n      = first;
        byte_data_n  = byte_data;
        byte_valid_n = 1'b0;
        byte_sof_n   = 1'b0;
        frame_done_n = 1'b0;
        frame_good_n = frame_good;
        frame_len_n  = frame_len;
        err_fcs_n    = err_fcs;
        err_align_n  = err_align;
        err_len_n    = err_len;

        case (state)
            S_IDLE: begin
                if (rx_dv) begin
                    state_n   = S_PRE;
                    sr_n      = sr_shift;
                    pre_cnt_n = PRE_W'(1);
                end
            end

            S_PRE: begin
                if (!rx_dv) begin
                    state_n = S_IDLE;
                end else begin
                    sr_n      = sr_shift;
                    pre_cnt_n = pre_cnt_inc;
                    // SFD wins over the hunt limit when both land on the same bit
                    if (sr_shift == SFD && pre_cnt_inc >= PRE_W'(8)) begin
                        state_n    = S_DATA;
                        bit_cnt_n  = 3'd0;
                        byte_cnt_n = '0;
                        first_n    = 1'b1;
                    end else if (pre_cnt_inc >= PRE_W'(MAX_PRE_BITS)) begin
                        state_n = S_DROP;
                    end
                end
            end

            S_DATA: begin
                if (rx_dv) begin
                    sr_n      = sr_shift;
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        if (byte_cnt >= LEN_W'(MAX_LEN)) begin
                            state_n      = S_DROP;
                            frame_done_n = 1'b1;
                            frame_good_n = 1'b0;
                            frame_len_n  = LEN_W'(MAX_LEN);
                            err_fcs_n    = 1'b0;
                            err_align_n  = 1'b0;
                            err_len_n    = 1'b1;
                        end else begin
                            byte_data_n  = sr_shift;
                            byte_valid_n = 1'b1;
                            byte_sof_n   = first;
                            first_n      = 1'b0;
                            byte_cnt_n   = byte_cnt + LEN_W'(1);
                        end
                    end
                end else begin
                    state_n      = S_IDLE;
                    frame_done_n = 1'b1;
                    frame_len_n  = byte_cnt;
                    err_align_n  = (bit_cnt != 3'd0);
                    err_fcs_n    = !fcs_ok;
                    err_len_n    = (byte_cnt < LEN_W'(MIN_LEN));
                    frame_good_n = (bit_cnt == 3'd0) && fcs_ok &&
                                   (byte_cnt >= LEN_W'(MIN_LEN));
                end
            end

            S_DROP: begin
                if (!rx_dv) begin
                    state_n = S_IDLE;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            sr         <= '0;
            pre_cnt    <= '0;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            first      <= 1'b0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            byte_sof   <= 1'b0;
            frame_done <= 1'b0;
            frame_good <= 1'b0;
            frame_len  <= '0;
            err_fcs    <= 1'b0;
            err_align  <= 1'b0;
            err_len    <= 1'b0;
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            pre_cnt    <= pre_cnt_n;
            bit_cnt    <= bit_cnt_n;
            byte_cnt   <= byte_cnt_n;
            first      <= first_n;
            byte_data  <= byte_data_n;
            byte_valid <= byte_valid_n;
            byte_sof   <= byte_sof_n;
            frame_done <= frame_done_n;
            frame_good <= frame_good_n;
            frame_len  <= frame_len_n;
            err_fcs    <= err_fcs_n;
            err_align  <= err_align_n;
            err_len    <= err_len_n;
        end
    end

`ifdef ETH_RX_STATS_EN
    logic [15:0] stat_good_n, stat_bad_n;

    // Saturating counters advance together with the frame_done they describe
    always_comb begin
        stat_good_n = stat_good;
        stat_bad_n  = stat_bad;
        if (frame_done_n) begin
            if (frame_good_n) begin
                if (stat_good != 16'hFFFF) stat_good_n = stat_good + 16'd1;
            end else begin
                if (stat_bad != 16'hFFFF) stat_bad_n = stat_bad + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_good <= '0;
            stat_bad  <= '0;
        end else begin
            stat_good <= stat_good_n;
            stat_bad  <= stat_bad_n;
        end
    end
`else
    assign stat_good = '0;
    assign stat_bad  = '0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_ctrl.sv
// Scoreboard bench for eth_rx_frame_ctrl with a bit-serial CRC-32 checker model on the FCS port.
// Stat counters are expected to count only when ETH_RX_STATS_EN is defined.
module tb_eth_rx_frame_ctrl;

    localparam int MIN_LEN      = 64;
    localparam int MAX_LEN      = 1518;
    localparam int MAX_PRE_BITS = 64;
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
`ifdef ETH_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
    } exp_byte_t;

    typedef struct packed {
        logic [10:0] len;
        logic        good;
        logic        fcs;
        logic        align;
        logic        lenerr;
    } exp_frame_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_dv;
    logic        rx_bit;
    logic        fcs_rst, fcs_en, fcs_bit, fcs_ok;
    logic [7:0]  byte_data;
    logic        byte_valid, byte_sof, frame_done, frame_good;
    logic [10:0] frame_len;
    logic        err_fcs, err_align, err_len;
    logic [15:0] stat_good, stat_bad;

    logic [31:0] crc_q;
    logic        rst_q = 1'b0;

    exp_byte_t   exp_bytes[$];
    exp_frame_t  exp_frames[$];

    int          checks = 0;
    int          errors = 0;
    int          mg = 0;
    int          mb = 0;
    logic [10:0] last_len = '0;
    logic        last_good = 1'b0;
    logic        drain_req = 1'b0;
    logic        drain_ack = 1'b0;
    int          drain_cnt = 0;

    eth_rx_frame_ctrl #(
        .MIN_LEN      (MIN_LEN),
        .MAX_LEN      (MAX_LEN),
        .MAX_PRE_BITS (MAX_PRE_BITS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_dv      (rx_dv),
        .rx_bit     (rx_bit),
        .fcs_rst    (fcs_rst),
        .fcs_en     (fcs_en),
        .fcs_bit    (fcs_bit),
        .fcs_ok     (fcs_ok),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_sof   (byte_sof),
        .frame_done (frame_done),
        .frame_good (frame_good),
        .frame_len  (frame_len),
        .err_fcs    (err_fcs),
        .err_align  (err_align),
        .err_len    (err_len),
        .stat_good  (stat_good),
        .stat_bad   (stat_bad)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        logic [31:0] r;
        r = {1'b0, c[31:1]};
        if (c[0] ^ b) r = r ^ 32'hEDB88320;
        return r;
    endfunction

    // External FCS checker: reflected CRC-32, residue match after data plus FCS
    always @(posedge clk) begin
        if (fcs_rst) crc_q <= '1;
        else if (fcs_en) crc_q <= crc_step(crc_q, fcs_bit);
    end
    assign fcs_ok = (crc_q == RESIDUE);

    always @(posedge clk) rst_q <= reset;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output event is matched against the head of the expectation queues
    always @(negedge clk) begin
        exp_byte_t  eb;
        exp_frame_t ef;
        if (rst_q) begin
            chk("reset_outputs", 32'({byte_valid, byte_sof, frame_done, frame_good,
                                      err_fcs, err_align, err_len, |byte_data, |frame_len,
                                      |stat_good, |stat_bad, fcs_en, ~fcs_rst}), 32'd0);
            mg = 0;
            mb = 0;
            last_len = '0;
            last_good = 1'b0;
        end else begin
            if (byte_valid) begin
                if (exp_bytes.size() == 0) begin
                    chk("unexpected_byte", 32'(byte_valid), 32'd0);
                end else begin
                    eb = exp_bytes.pop_front();
                    chk("byte_data", 32'(byte_data), 32'(eb.data));
                    chk("byte_sof", 32'(byte_sof), 32'(eb.sof));
                end
            end else if (byte_sof) begin
                chk("stray_sof", 32'(byte_sof), 32'd0);
            end
            if (frame_done) begin
                if (exp_frames.size() == 0) begin
                    chk("unexpected_frame", 32'(frame_done), 32'd0);
                end else begin
                    ef = exp_frames.pop_front();
                    chk("frame_len", 32'(frame_len), 32'(ef.len));
                    chk("frame_good", 32'(frame_good), 32'(ef.good));
                    chk("err_fcs", 32'(err_fcs), 32'(ef.fcs));
                    chk("err_align", 32'(err_align), 32'(ef.align));
                    chk("err_len", 32'(err_len), 32'(ef.lenerr));
                    if (ef.good) mg++;
                    else mb++;
                    last_len = ef.len;
                    last_good = ef.good;
                    chk("stat_good", 32'(stat_good), STATS ? 32'(mg) : 32'd0);
                    chk("stat_bad", 32'(stat_bad), STATS ? 32'(mb) : 32'd0);
                end
            end
        end
        if (!drain_req) begin
            drain_ack = 1'b0;
            drain_cnt = 0;
        end else if (!drain_ack) begin
            drain_cnt++;
            if ((exp_bytes.size() == 0 && exp_frames.size() == 0) || drain_cnt > 64) begin
                chk("drain_pending", 32'(exp_bytes.size() + exp_frames.size()), 32'd0);
                chk("hold_len", 32'(frame_len), 32'(last_len));
                chk("hold_good", 32'(frame_good), 32'(last_good));
                drain_ack = 1'b1;
            end
        end
    end

    task automatic drive(input logic dv, input logic b);
        @(posedge clk);
        #1;
        rx_dv  = dv;
        rx_bit = b;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        rx_dv  = 1'b0;
        rx_bit = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic drain();
        drain_req = 1'b1;
        wait (drain_ack);
        drain_req = 1'b0;
        wait (!drain_ack);
    endtask

    // Builds a burst, predicts its outcome from frame-level rules, then drives it bit by bit
    task automatic send_burst(input int pre_bytes, input int pay_len, input bit rand_pay,
                              input int flip_idx, input int extra, input int reset_at);
        logic [7:0]  fb[$];
        logic        dbits[$];
        logic [7:0]  pb;
        logic [31:0] c;
        int          n;
        exp_byte_t   eb;
        exp_frame_t  ef;

        for (int i = 0; i < pay_len; i++) fb.push_back(rand_pay ? 8'($urandom) : 8'h00);
        c = '1;
        foreach (fb[i]) begin
            pb = fb[i];
            repeat (8) begin
                c  = crc_step(c, pb[0]);
                pb = pb >> 1;
            end
        end
        c = ~c;
        repeat (4) begin
            fb.push_back(c[7:0]);
            c = c >> 8;
        end
        if (flip_idx >= 0) fb[flip_idx / 8] = fb[flip_idx / 8] ^ (8'd1 << (flip_idx % 8));
        foreach (fb[i]) begin
            pb = fb[i];
            repeat (8) begin
                dbits.push_back(pb[0]);
                pb = pb >> 1;
            end
        end
        for (int i = 0; i < extra; i++) dbits.push_back(1'($urandom));
        n = fb.size();

        if (pre_bytes * 8 + 8 <= MAX_PRE_BITS) begin
            if (reset_at >= 0) begin
                for (int i = 0; i < reset_at / 8; i++) begin
                    eb.data = fb[i];
                    eb.sof  = (i == 0);
                    exp_bytes.push_back(eb);
                end
            end else begin
                for (int i = 0; i < n && i < MAX_LEN; i++) begin
                    eb.data = fb[i];
                    eb.sof  = (i == 0);
                    exp_bytes.push_back(eb);
                end
                if (n > MAX_LEN) begin
                    ef.len    = 11'(MAX_LEN);
                    ef.good   = 1'b0;
                    ef.fcs    = 1'b0;
                    ef.align  = 1'b0;
                    ef.lenerr = 1'b1;
                end else begin
                    c = '1;
                    foreach (dbits[i]) c = crc_step(c, dbits[i]);
                    ef.len    = 11'(n);
                    ef.fcs    = (c != RESIDUE);
                    ef.align  = (extra != 0);
                    ef.lenerr = (n < MIN_LEN);
                    ef.good   = !(ef.fcs || ef.align || ef.lenerr);
                end
                exp_frames.push_back(ef);
            end
        end

        for (int i = 0; i < pre_bytes * 8; i++) drive(1'b1, 1'((i % 2) == 0));
        pb = 8'hD5;
        repeat (8) begin
            drive(1'b1, pb[0]);
            pb = pb >> 1;
        end
        for (int i = 0; i < dbits.size(); i++) begin
            if (i == reset_at) begin
                pulse_reset();
                break;
            end
            drive(1'b1, dbits[i]);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pre, pay, sel, flip, ext;
        reset  = 1'b1;
        rx_dv  = 1'b0;
        rx_bit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);

        send_burst(7, 60, 1'b0, -1, 0, -1);    idle(6); drain();  // good minimum frame
        send_burst(7, 60, 1'b0, 37, 0, -1);    idle(6); drain();  // payload bit flipped
        send_burst(7, 60, 1'b1, -1, 3, -1);    idle(6); drain();  // trailing odd bits
        send_burst(7, 36, 1'b1, -1, 0, -1);    idle(6); drain();  // 40-byte runt
        send_burst(7, 59, 1'b1, -1, 0, -1);    idle(6); drain();  // 63 bytes
        send_burst(8, 60, 1'b1, -1, 0, -1);    idle(6); drain();  // preamble too long
        send_burst(0, 60, 1'b1, -1, 0, -1);    idle(6); drain();  // SFD only
        send_burst(7, 1596, 1'b1, -1, 0, -1);  idle(6); drain();  // oversize burst
        send_burst(7, 60, 1'b1, -1, 0, -1);    idle(1);           // back-to-back
        send_burst(7, 1514, 1'b1, -1, 0, -1);  idle(6); drain();  // maximum length
        send_burst(7, 60, 1'b1, -1, 0, 163);   idle(6); drain();  // reset mid-frame
        send_burst(7, 60, 1'b0, -1, 0, -1);    idle(6); drain();

        for (int t = 0; t < 20; t++) begin
            pre  = int'($urandom_range(0, 7));
            pay  = int'($urandom_range(20, 116));
            sel  = int'($urandom_range(0, 3));
            flip = (sel == 1) ? int'($urandom_range(0, (pay + 4) * 8 - 1)) : -1;
            ext  = (sel == 2) ? int'($urandom_range(1, 7)) : 0;
            send_burst(pre, pay, 1'b1, flip, ext, -1);
            idle(int'($urandom_range(1, 12)));
        end
        idle(4);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_rx_frame_ctrl.md
Name: eth_rx_frame_ctrl

Overview:
- Sequences the bit-serial Ethernet receive path: one line bit per clock, with a data-valid qualifier.
- Hunts preamble/SFD, then drives the external bit-serial FCS checker's reset, enable and data inputs.
- Deserialises frame bytes and reports per-frame status (FCS, alignment, length) to the downstream MAC buffer logic.
- Sits between the PHY-side bit recovery and the RX frame buffer.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes, DA through FCS inclusive.
- MAX_LEN, 1518, maximum legal frame length in bytes, DA through FCS inclusive.
- MAX_PRE_BITS, 64, maximum bits spent hunting for the SFD before abandoning the burst.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_dv  in  1  line data valid; one bit per clk while high
- rx_bit  in  1  serial line bit, LSB of each byte first
- fcs_rst  out  1  to FCS checker reset (combinational)
- fcs_en  out  1  to FCS checker enable (combinational)
- fcs_bit  out  1  to FCS checker data input (combinational)
- fcs_ok  in  1  FCS checker residue-match flag
- byte_data  out  8  assembled byte
- byte_valid  out  1  one-cycle pulse per byte
- byte_sof  out  1  qualifies byte_valid for the first byte after SFD
- frame_done  out  1  one-cycle end-of-frame pulse
- frame_good  out  1  valid with frame_done
- frame_len  out  11  bytes received, FCS included; valid with frame_done
- err_fcs  out  1  valid with frame_done
- err_align  out  1  valid with frame_done
- err_len  out  1  valid with frame_done
- stat_good  out  16  see Optional Feature
- stat_bad  out  16  see Optional Feature

Behaviour:
- Reset:
  - State goes to IDLE.
  - All registered outputs go to 0, including counters and shift register.
  - Reset mid-frame abandons the frame silently: no frame_done.
- Shift register sr[7:0]:
  - Updated as sr <= {rx_bit, sr[7:1]} on every cycle with rx_dv=1 in PRE or DATA.
- IDLE:
  - On rx_dv=1, go to PRE; the first bit is shifted in.
  - pre_cnt := 1.
- PRE:
  - rx_dv=0 -> IDLE, no report.
  - Post-shift value == 8'hD5 with pre_cnt >= 8 -> DATA; bit_cnt := 0, byte_cnt := 0, first := 1.
  - pre_cnt reaching MAX_PRE_BITS without SFD -> DROP, no report.
- DATA, rx_dv=1:
  - Bit is shifted into sr; bit_cnt increments mod 8.
  - On the 8th bit: byte_data <= assembled byte and byte_valid <= 1 (next cycle).
  - byte_sof <= first, then first := 0; byte_cnt increments.
  - byte_cnt would exceed MAX_LEN -> DROP. Emit frame_done next cycle with err_len=1, frame_good=0, frame_len=MAX_LEN, err_fcs=0, err_align=0.
- DATA, rx_dv=0 (end of frame):
  - Next cycle: frame_done=1, frame_len=byte_cnt.
  - err_align = (bit_cnt != 0).
  - err_fcs = !fcs_ok, sampled this cycle.
  - err_len = (byte_cnt < MIN_LEN).
  - frame_good = no error flag set.
  - State -> IDLE.
- DROP:
  - Wait for rx_dv=0, then -> IDLE.
  - Bits are ignored; no byte_valid.
- FCS interface:
  - fcs_bit = rx_bit.
  - fcs_en = (state==DATA) && rx_dv.
  - fcs_rst = reset || (state != DATA).
  - The checker therefore starts from all-ones on the first DATA bit.
  - fcs_ok reflects all frame bits on the rx_dv-fall cycle.
- Latency:
  - byte_valid occurs 1 clk after the byte's 8th bit.
  - frame_done occurs 1 clk after the rx_dv-fall cycle.
- Pulse outputs and status fields:
  - byte_valid, byte_sof and frame_done are single-cycle pulses.
  - Status fields hold until the next frame_done.
- FCS bytes are delivered on byte_data like payload; the consumer strips the last 4.
- rx_dv rising in the same cycle as the frame_done pulse is legal: IDLE -> PRE proceeds normally.

Optional Feature:
- Macro: ETH_RX_STATS_EN.
- Defined:
  - stat_good increments on frame_done with frame_good=1.
  - stat_bad increments on frame_done with frame_good=0, including DROP-on-length.
  - Both counters are 16-bit and saturate at 16'hFFFF.
  - Both are cleared by reset.
- Undefined:
  - Counter logic is absent.
  - stat_good and stat_bad are tied to 0.

Test Plan:
- 56 bits of 0x55, then SFD 0xD5, 60 zero bytes plus correct FCS (bench-computed) -> 64 byte_valid pulses, byte_sof on the first only. frame_done with frame_good=1 and frame_len=64; stat_good=1 if enabled.
- Same frame with one payload bit flipped -> frame_done, err_fcs=1, frame_good=0, frame_len=64.
- Valid 64-byte frame plus 3 extra bits before rx_dv falls -> err_align=1, frame_len=64, byte_valid count 64.
- 40-byte frame with correct FCS -> err_len=1, err_fcs=0, frame_len=40, frame_good=0.
- 1600-byte burst -> after byte 1518: frame_done with err_len=1 and frame_len=1518. No further byte_valid until rx_dv falls; the next frame is received normally.
- Pulse reset at byte 20 of a frame -> no frame_done, all outputs 0, fcs_rst=1. The following good frame is reported good.
